button_debounce_repeat: RTL
===========================

BUTTON_DEBOUNCE_REPEAT -- requirements
Module: button_debounce_repeat

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required to accept a level change (>=1).
REQ-002 Parameter: HOLD_CYCLES, 20, pressed-state cycles before auto-repeat starts (>=1).
REQ-003 Parameter: REPEAT_CYCLES, 8, cycles between auto-repeat pulses (>=1).
REQ-004 Parameter: REPEAT_EN, 1, 1 enables auto-repeat; 0 gives one pulse per press.
REQ-005 Parameter: ACTIVE_LOW, 1, 1 means raw button reads 0 when pressed.
REQ-006 Port: clock input 1, system clock; all state on rising edge.
REQ-007 Port: reset input 1, asynchronous, active-high.
REQ-008 Port: button_signal input 1, raw asynchronous button pin.
REQ-009 Port: button_flag output 1, one-cycle pulse per accepted press and per repeat.
REQ-010 Port: release_flag output 1, one-cycle pulse per accepted release.
REQ-011 Port: button_level output 1, debounced level, 1 = pressed.
REQ-012 Port: button_held output 1, high while in auto-repeat.

Function
REQ-013 button_signal passes a 2-flop synchronizer, then normalized to active-high using ACTIVE_LOW; all further logic uses the normalized sample.
REQ-014 FSM states: IDLE, PRESS_WAIT, PRESSED, REPEAT, RELEASE_WAIT.
REQ-015 IDLE: active sample -> PRESS_WAIT, debounce counter loaded to 1.
REQ-016 PRESS_WAIT: active sample increments counter; inactive sample -> IDLE with no output; on DEBOUNCE_CYCLES-th consecutive active sample -> PRESSED.
REQ-017 Entry into PRESSED raises button_flag for exactly one cycle and sets button_level; press latency = DEBOUNCE_CYCLES+2 clock edges from first edge sampling a clean active pin.
REQ-018 PRESSED: hold counter counts active cycles; on reaching HOLD_CYCLES with REPEAT_EN=1 -> REPEAT, button_held=1, button_flag pulsed that cycle; with REPEAT_EN=0 counter saturates, no further pulses.
REQ-019 REPEAT: button_flag pulses every REPEAT_CYCLES cycles while sample active; repeat counter wraps to 0 after each pulse.
REQ-020 PRESSED or REPEAT: inactive sample -> RELEASE_WAIT, debounce counter loaded to 1, button_level stays 1.
REQ-021 RELEASE_WAIT: DEBOUNCE_CYCLES consecutive inactive samples -> IDLE, release_flag pulsed one cycle, button_level and button_held cleared same cycle.
REQ-022 RELEASE_WAIT: active sample before completion -> PRESSED, hold and repeat counters cleared, button_held cleared, no button_flag.
REQ-023 button_flag and release_flag never high in the same cycle; all outputs registered.
REQ-024 Counter widths = $clog2(max(param)+1); no counter overflows for any legal parameter.

Reset
REQ-025 reset asserted: FSM -> IDLE, all counters 0, synchronizer flops to inactive pin level, all outputs 0, immediately and independent of clock.
REQ-026 Button held through reset deassertion: treated as new press, button_flag after DEBOUNCE_CYCLES+2 edges.
REQ-027 Reset mid-PRESSED/REPEAT: no release_flag generated.

Structure
REQ-028 Shared package button_pkg holds FSM state encoding and default parameter constants.
REQ-029 One sub-module sync_2ff (parameterized reset value) implements the synchronizer.
REQ-030 Downstream counters consume button_flag directly as a one-cycle increment/decrement enable.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8, ACTIVE_LOW=1)
REQ-031 Clean press: pin 1->0 held 10 cycles -> one button_flag at edge 6, button_level=1, no repeat.
REQ-032 Bounce: pin toggles every 2 cycles for 12 cycles then low -> no flag during bounce, exactly one flag 6 edges after last toggle.
REQ-033 Long hold 60 cycles -> flags at press, at +20 cycles, then every 8 cycles (total 6), button_held=1 from first repeat; release_flag once after release debounce.
REQ-034 Release glitch: pin high for 2 cycles during PRESSED -> no release_flag, no extra button_flag, hold counter restarts.
REQ-035 Reset mid-REPEAT with pin low -> outputs 0 immediately; after deassertion one flag at +6 edges, no release_flag.
REQ-036 REPEAT_EN=0, hold 60 cycles -> exactly one button_flag, button_held stays 0.

Source files
------------

// File: rtl/button_pkg.sv
// Shared definitions for the button debounce / auto-repeat block.
// Holds the FSM state encoding, the default parameter values and a helper
// that sizes the internal counters from the timing parameters.
package button_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE         = 3'd0;
    localparam logic [2:0] ST_PRESS_WAIT   = 3'd1;
    localparam logic [2:0] ST_PRESSED      = 3'd2;
    localparam logic [2:0] ST_REPEAT       = 3'd3;
    localparam logic [2:0] ST_RELEASE_WAIT = 3'd4;

    // Default timing / behaviour parameters
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_HOLD_CYCLES     = 20;
    localparam int DEF_REPEAT_CYCLES   = 8;
    localparam bit DEF_REPEAT_EN       = 1'b1;
    localparam bit DEF_ACTIVE_LOW      = 1'b1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // One width shared by all counters, wide enough for the largest terminal
    // count so none of them can wrap.
    function automatic int cnt_width(input int d, input int h, input int r);
        return $clog2(max3(d, h, r) + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Ports:
//   clock  - destination clock
//   reset  - asynchronous, active-high; both flops load RESET_VAL
//   d_i    - asynchronous input
//   q_o    - synchronized output (two clock edges of latency)
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/button_debounce_repeat.sv
// Push-button conditioner: synchronizes the raw pin, debounces press and
// release, and optionally generates auto-repeat pulses while held.
// Ports:
//   clock         - system clock, all state on the rising edge
//   reset         - asynchronous, active-high
//   button_signal - raw asynchronous button pin (polarity set by ACTIVE_LOW)
//   button_flag   - one-cycle pulse per accepted press and per repeat
//   release_flag  - one-cycle pulse per accepted release
//   button_level  - debounced level, 1 = pressed
//   button_held   - high while auto-repeat is active
module button_debounce_repeat
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter bit REPEAT_EN       = DEF_REPEAT_EN,
    parameter bit ACTIVE_LOW      = DEF_ACTIVE_LOW
) (
    input  logic clock,
    input  logic reset,
    input  logic button_signal,
    output logic button_flag,
    output logic release_flag,
    output logic button_level,
    output logic button_held
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);

    // Counters compare against "last" values: the transition happens on the
    // sample that would bring the count to the parameter value.
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    // Pin level that means "not pressed"; the synchronizer resets to it so
    // leaving reset never looks like an edge by itself.
    localparam logic PIN_IDLE = ACTIVE_LOW;

    logic             pin_sync;
    logic             sample_active;

    logic [2:0]       state_q,    state_d;
    logic [CNT_W-1:0] deb_cnt_q,  deb_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0] rep_cnt_q,  rep_cnt_d;
    logic             flag_q,     flag_d;
    logic             rel_q,      rel_d;
    logic             level_q,    level_d;
    logic             held_q,     held_d;

    sync_2ff #(
        .RESET_VAL (PIN_IDLE)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .d_i   (button_signal),
        .q_o   (pin_sync)
    );

    // Normalize to active-high.
    assign sample_active = pin_sync ^ ACTIVE_LOW;

    always_comb begin
        state_d    = state_q;
        deb_cnt_d  = deb_cnt_q;
        hold_cnt_d = hold_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        flag_d     = 1'b0;
        rel_d      = 1'b0;
        level_d    = level_q;
        held_d     = held_q;

        case (state_q)
            ST_IDLE: begin
                if (sample_active) begin
                    if (DEB_LAST == CNT_ZERO) begin
                        // Single-sample debounce: this sample completes it.
                        state_d    = ST_PRESSED;
                        flag_d     = 1'b1;
                        level_d    = 1'b1;
                        deb_cnt_d  = CNT_ZERO;
                        hold_cnt_d = CNT_ZERO;
                        rep_cnt_d  = CNT_ZERO;
                    end else begin
                        state_d   = ST_PRESS_WAIT;
                        deb_cnt_d = CNT_ONE;
                    end
                end
            end

            ST_PRESS_WAIT: begin
                if (!sample_active) begin
                    state_d   = ST_IDLE;
                    deb_cnt_d = CNT_ZERO;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d    = ST_PRESSED;
                    flag_d     = 1'b1;
                    level_d    = 1'b1;
                    deb_cnt_d  = CNT_ZERO;
                    hold_cnt_d = CNT_ZERO;
                    rep_cnt_d  = CNT_ZERO;
                end else begin
                    deb_cnt_d = deb_cnt_q + CNT_ONE;
                end
            end

            ST_PRESSED, ST_REPEAT: begin
                if (!sample_active) begin
                    if (DEB_LAST == CNT_ZERO) begin
                        state_d    = ST_IDLE;
                        rel_d      = 1'b1;
                        level_d    = 1'b0;
                        held_d     = 1'b0;
                        deb_cnt_d  = CNT_ZERO;
                        hold_cnt_d = CNT_ZERO;
                        rep_cnt_d  = CNT_ZERO;
                    end else begin
                        // Level stays asserted until the release is confirmed.
                        state_d   = ST_RELEASE_WAIT;
                        deb_cnt_d = CNT_ONE;
                    end
                end else if (state_q == ST_PRESSED) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        if (REPEAT_EN) begin
                            state_d   = ST_REPEAT;
                            flag_d    = 1'b1;
                            held_d    = 1'b1;
                            rep_cnt_d = CNT_ZERO;
                        end
                        // Without repeat the hold counter simply parks here.
                    end else begin
                        hold_cnt_d = hold_cnt_q + CNT_ONE;
                    end
                end else begin
                    if (rep_cnt_q == REP_LAST) begin
                        flag_d    = 1'b1;
                        rep_cnt_d = CNT_ZERO;
                    end else begin
                        rep_cnt_d = rep_cnt_q + CNT_ONE;
                    end
                end
            end

            ST_RELEASE_WAIT: begin
                if (sample_active) begin
                    // Release glitch: back to a fresh hold period, silently.
                    state_d    = ST_PRESSED;
                    deb_cnt_d  = CNT_ZERO;
                    hold_cnt_d = CNT_ZERO;
                    rep_cnt_d  = CNT_ZERO;
                    held_d     = 1'b0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d    = ST_IDLE;
                    rel_d      = 1'b1;
                    level_d    = 1'b0;
                    held_d     = 1'b0;
                    deb_cnt_d  = CNT_ZERO;
                    hold_cnt_d = CNT_ZERO;
                    rep_cnt_d  = CNT_ZERO;
                end else begin
                    deb_cnt_d = deb_cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                deb_cnt_d  = CNT_ZERO;
                hold_cnt_d = CNT_ZERO;
                rep_cnt_d  = CNT_ZERO;
                level_d    = 1'b0;
                held_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            deb_cnt_q  <= '0;
            hold_cnt_q <= '0;
            rep_cnt_q  <= '0;
            flag_q     <= 1'b0;
            rel_q      <= 1'b0;
            level_q    <= 1'b0;
            held_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            deb_cnt_q  <= deb_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            flag_q     <= flag_d;
            rel_q      <= rel_d;
            level_q    <= level_d;
            held_q     <= held_d;
        end
    end

    assign button_flag  = flag_q;
    assign release_flag = rel_q;
    assign button_level = level_q;
    assign button_held  = held_q;

endmodule
